// File: rtl/tx_block.sv
// tx_block: 8N1 serial transmitter with a one-entry holding buffer.
// Defining TX_PARITY_EN adds an even-parity bit between data and stop.
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       data_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       overrun_error,
  output logic       serial_out
);

  localparam int TW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            full_q, full_d;
  logic            ovr_q, ovr_d;
  logic            out_q, out_d;
`ifdef TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic bit_end;
  logic transfer;
  logic wr_ok;
  logic drop;

  // The buffer may be refilled in the same cycle it drains into the shifter.
  always_comb begin
    bit_end  = (timer_q == T_LAST);
    transfer = full_q &&
               ((state_q == S_IDLE) ||
                ((state_q == S_STOP) && bit_end));
    wr_ok    = data_valid && (!full_q || transfer);
    drop     = data_valid && full_q && !transfer;
  end

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    ovr_d  = drop;
    if (wr_ok) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end else if (transfer) begin
      full_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif
    if (bit_end || state_q == S_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (transfer) begin
      state_d = S_START;
      shift_d = hold_q;
      bit_d   = 3'd0;
`ifdef TX_PARITY_EN
      par_d   = ^hold_q;
`endif
    end
  end

  // Line level is computed from the next state so the output is a clean flop.
  always_comb begin
    out_d = 1'b1;
    unique case (state_d)
      S_IDLE:   out_d = 1'b1;
      S_START:  out_d = 1'b0;
      S_DATA:   out_d = shift_d[0];
`ifdef TX_PARITY_EN
      S_PARITY: out_d = par_q;
`endif
      S_STOP:   out_d = 1'b1;
      default:  out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      hold_q  <= 8'h00;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      out_q   <= out_d;
    end
  end

`ifdef TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign tx_ready      = !full_q;
  assign tx_busy       = (state_q != S_IDLE);
  assign overrun_error = ovr_q;
  assign serial_out    = out_q;

endmodule

// File: tb/tb_tx_block.sv
// tb_tx_block: vector table plus a line-decoding scoreboard for tx_block.
// Frame bits are checked on every clock of every bit.
module tb_tx_block;

  localparam int BP = 10;
`ifdef TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       data_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       overrun_error;
  logic       serial_out;

  int checks;
  int errors;
  int cyc;
  int nfr;
  int start_cyc [0:15];
  bit mon_en;
  bit in_frame;
  exp_t sb [$];
  exp_t vec [0:5];

  tx_block #(.BIT_PERIOD(BP)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_data       (tx_data),
    .data_valid    (data_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .overrun_error (overrun_error),
    .serial_out    (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the strobe for exactly one rising edge.
  task automatic wr(input logic [7:0] d);
    tx_data    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy || in_frame) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", int'(n >= limit), 0);
  endtask

  // Line receiver: decodes each frame and compares against the scoreboard.
  initial begin
    exp_t e;
    logic fb [0:10];
    bit ok;
    forever begin
      @(negedge clk);
      if (mon_en && n_rst && !in_frame && serial_out === 1'b0) begin
        in_frame = 1'b1;
        start_cyc[nfr % 16] = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          e.data = 8'h00;
          e.par  = 1'b0;
        end else begin
          e = sb.pop_front();
        end
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = e.data[i];
        fb[9]  = (FB == 11) ? e.par : 1'b1;
        fb[10] = 1'b1;
        for (int b = 0; b < FB; b++) begin
          ok = 1'b1;
          for (int c = 0; c < BP; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (serial_out !== fb[b]) ok = 1'b0;
          end
          chk($sformatf("frame%0d_%02h_bit%0d", nfr, e.data, b), int'(ok), 1);
        end
        nfr++;
        in_frame = 1'b0;
      end
    end
  end

  initial begin
    exp_t x;
    int s0;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    nfr        = 0;
    mon_en     = 1'b0;
    in_frame   = 1'b0;
    n_rst      = 1'b0;
    tx_data    = 8'h00;
    data_valid = 1'b0;

    vec[0] = '{8'hA5, 1'b0};
    vec[1] = '{8'h00, 1'b0};
    vec[2] = '{8'hFF, 1'b0};
    vec[3] = '{8'h07, 1'b1};
    vec[4] = '{8'h03, 1'b0};
    vec[5] = '{8'h80, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_serial_out", int'(serial_out), 1);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_tx_busy", int'(tx_busy), 0);
    chk("rst_overrun", int'(overrun_error), 0);
    n_rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      chk($sformatf("v%0d_ready_pre", v), int'(tx_ready), 1);
      chk($sformatf("v%0d_busy_pre", v), int'(tx_busy), 0);
      sb.push_back(vec[v]);
      wr(vec[v].data);
      chk($sformatf("v%0d_ready_n", v), int'(tx_ready), 0);
      chk($sformatf("v%0d_busy_n", v), int'(tx_busy), 0);
      chk($sformatf("v%0d_line_n", v), int'(serial_out), 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_start", v), int'(tx_busy), 1);
      chk($sformatf("v%0d_ready_start", v), int'(tx_ready), 1);
      chk($sformatf("v%0d_line_start", v), int'(serial_out), 0);
      repeat (FB*BP - 1) @(negedge clk);
      chk($sformatf("v%0d_busy_last", v), int'(tx_busy), 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_end", v), int'(tx_busy), 0);
      chk($sformatf("v%0d_line_end", v), int'(serial_out), 1);
      wait_done(4*FB*BP);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: second byte written while the first is in DATA.
    s0 = nfr;
    x = '{8'h00, 1'b0};
    sb.push_back(x);
    wr(8'h00);
    repeat (3*BP) @(negedge clk);
    x = '{8'hFF, 1'b0};
    sb.push_back(x);
    wr(8'hFF);
    wait_done(6*FB*BP);
    chk("b2b_frames", nfr - s0, 2);
    chk("b2b_gap", start_cyc[(s0+1)%16] - start_cyc[s0%16], FB*BP);
    repeat (3) @(negedge clk);

    // Overrun: three writes on consecutive clocks, third one dropped.
    s0 = nfr;
    x = '{8'h11, 1'b0};
    sb.push_back(x);
    x = '{8'h22, 1'b0};
    sb.push_back(x);
    wr(8'h11);
    wr(8'h22);
    chk("ovr_none_yet", int'(overrun_error), 0);
    wr(8'h33);
    chk("ovr_pulse", int'(overrun_error), 1);
    chk("ovr_ready", int'(tx_ready), 0);
    @(negedge clk);
    chk("ovr_single", int'(overrun_error), 0);
    wait_done(6*FB*BP);
    chk("ovr_frames", nfr - s0, 2);
    chk("ovr_gap", start_cyc[(s0+1)%16] - start_cyc[s0%16], FB*BP);
    repeat (3) @(negedge clk);

    // Mid-frame reset during data bit 3 of 0xC3 (bit 3 is 0).
    mon_en = 1'b0;
    wr(8'hC3);
    repeat (1 + 4*BP + BP/2) @(negedge clk);
    chk("mrst_line_pre", int'(serial_out), 0);
    chk("mrst_busy_pre", int'(tx_busy), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("mrst_line", int'(serial_out), 1);
    chk("mrst_busy", int'(tx_busy), 0);
    chk("mrst_ready", int'(tx_ready), 1);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle_line", int'(serial_out), 1);
    mon_en = 1'b1;
    s0 = nfr;
    x = '{8'h3C, 1'b0};
    sb.push_back(x);
    wr(8'h3C);
    wait_done(4*FB*BP);
    chk("mrst_frames", nfr - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
